// File: rtl/lk_destport_queue_pkg.sv
// Shared widths and log2 helper for the look-ahead destination-port queue.
// These definitions are also used by the routing and VC-allocation blocks.
package lk_destport_queue_pkg;

    localparam int unsigned LKDP_V         = 4;
    localparam int unsigned LKDP_DSTPW     = 4;
    localparam int unsigned LKDP_PKT_DEPTH = 2;

    // Ceiling log2; returns 0 for n <= 1.
    function automatic int unsigned lkdp_log2(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'(1) << i) < 64'(n)) r = i + 1;
        end
        return r;
    endfunction

    // Pointer needs at least one bit even when only one entry exists.
    function automatic int unsigned lkdp_ptr_w(input int unsigned depth);
        return (lkdp_log2(depth) == 0) ? 1 : lkdp_log2(depth);
    endfunction

    function automatic int unsigned lkdp_cnt_w(input int unsigned depth);
        return lkdp_log2(depth + 1);
    endfunction

    localparam int unsigned LKDP_DSTP_SEL_W = lkdp_log2(LKDP_DSTPW);
    localparam int unsigned LKDP_PTR_W      = lkdp_ptr_w(LKDP_PKT_DEPTH);
    localparam int unsigned LKDP_CNT_W      = lkdp_cnt_w(LKDP_PKT_DEPTH);

endpackage

// File: rtl/lk_destport_queue_if.sv
// Write/pop/status bundle between an input port's VC logic and its destport queue.
interface lk_destport_queue_if
    import lk_destport_queue_pkg::*;
#(
    parameter int unsigned V     = LKDP_V,
    parameter int unsigned DSTPw = LKDP_DSTPW
);
    logic [V-1:0]         wr_en;
    logic [DSTPw-1:0]     lkdestport_in;
    logic [V-1:0]         rd_en;
    logic [V*DSTPw-1:0]   lkdestport_out;
    logic [V-1:0]         lkdest_valid;
    logic [V-1:0]         full;
    logic                 overflow_err;

    modport master (
        output wr_en, lkdestport_in, rd_en,
        input  lkdestport_out, lkdest_valid, full, overflow_err
    );

    modport slave (
        input  wr_en, lkdestport_in, rd_en,
        output lkdestport_out, lkdest_valid, full, overflow_err
    );
endinterface

// File: rtl/lk_destport_queue_vc_queue.sv
// Single-VC circular buffer of look-ahead destports (lkdp_vc_queue).
// Optional LKDP_QUEUE_BYPASS_EN forwards a write into an empty queue combinationally.
module lkdp_vc_queue
    import lk_destport_queue_pkg::*;
#(
    parameter int unsigned DSTPw     = LKDP_DSTPW,
    parameter int unsigned PKT_DEPTH = LKDP_PKT_DEPTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_i,
    input  logic             rd_i,
    input  logic [DSTPw-1:0] data_i,
    output logic [DSTPw-1:0] data_o,
    output logic             valid_o,
    output logic             full_o,
    output logic             err_c_o
);
    localparam int unsigned PTR_W = lkdp_ptr_w(PKT_DEPTH);
    localparam int unsigned CNT_W = lkdp_cnt_w(PKT_DEPTH);

    logic [DSTPw-1:0] mem_q [PKT_DEPTH];
    logic [DSTPw-1:0] mem_d [PKT_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             empty, full, push, pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(PKT_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        empty = (count_q == '0);
        full  = (count_q == CNT_W'(PKT_DEPTH));
`ifdef LKDP_QUEUE_BYPASS_EN
        // Write+pop on an empty queue consumes the entry in flight.
        push    = wr_i & (~full | rd_i) & ~(empty & rd_i);
        pop     = rd_i & ~empty;
        err_c_o = (wr_i & full & ~rd_i) | (rd_i & empty & ~wr_i);
`else
        push    = wr_i & (~full | rd_i);
        pop     = rd_i & ~empty;
        err_c_o = (wr_i & full & ~rd_i) | (rd_i & empty);
`endif
    end

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = data_i;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end
        if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);
        if (push && !pop)      count_d = count_q + CNT_W'(1);
        else if (pop && !push) count_d = count_q - CNT_W'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(PKT_DEPTH); i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_comb begin
        data_o  = empty ? '0 : mem_q[rd_ptr_q];
        valid_o = ~empty;
        full_o  = full;
`ifdef LKDP_QUEUE_BYPASS_EN
        if (empty && wr_i) begin
            data_o  = data_i;
            valid_o = 1'b1;
        end
`endif
    end
endmodule

// File: rtl/lk_destport_queue.sv
// Per-VC look-ahead destport queues for one router input port; sticky overflow/underflow flag.
// Build option: LKDP_QUEUE_BYPASS_EN (same-cycle forwarding into an empty VC).
module lk_destport_queue
    import lk_destport_queue_pkg::*;
#(
    parameter int unsigned V         = LKDP_V,
    parameter int unsigned DSTPw     = LKDP_DSTPW,
    parameter int unsigned PKT_DEPTH = LKDP_PKT_DEPTH
) (
    input  logic                 clk,
    input  logic                 reset,
    lk_destport_queue_if.slave   q
);
    logic [V-1:0]       wr_sel;
    logic [V-1:0]       vc_err;
    logic [V-1:0]       vc_valid;
    logic [V-1:0]       vc_full;
    logic [V*DSTPw-1:0] vc_data;
    logic               overflow_err_q, overflow_err_d;

    // Only the lowest set write-enable bit is honoured.
    assign wr_sel = q.wr_en & (~q.wr_en + V'(1));

    for (genvar i = 0; i < int'(V); i++) begin : g_vc
        lkdp_vc_queue #(
            .DSTPw     (DSTPw),
            .PKT_DEPTH (PKT_DEPTH)
        ) u_vc (
            .clk     (clk),
            .reset   (reset),
            .wr_i    (wr_sel[i]),
            .rd_i    (q.rd_en[i]),
            .data_i  (q.lkdestport_in),
            .data_o  (vc_data[i*DSTPw +: DSTPw]),
            .valid_o (vc_valid[i]),
            .full_o  (vc_full[i]),
            .err_c_o (vc_err[i])
        );
    end

    assign overflow_err_d = overflow_err_q | (|vc_err);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) overflow_err_q <= 1'b0;
        else       overflow_err_q <= overflow_err_d;
    end

    assign q.lkdestport_out = vc_data;
    assign q.lkdest_valid   = vc_valid;
    assign q.full           = vc_full;
    assign q.overflow_err   = overflow_err_q;
endmodule
